// File: rtl/rat_rename_log_if.sv
// rat_rename_log_if: bundle of the rename-side push port and the commit-side
// pop/flush/RAT ports of the rename-order log.
//   master : the log itself (takes pushes/pops, drives the RAT ports)
//   slave  : rename + commit stages / RAT (drive pushes/pops, observe outputs)
// Lane counts come from `RENAME_WIDTH / `COMMIT_WIDTH; ID width from PHY_ID_W.
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef PHY_REG_ID_WIDTH
`define PHY_REG_ID_WIDTH 7
`endif

interface rat_rename_log_if #(
  parameter int PHY_ID_W = `PHY_REG_ID_WIDTH
);
  logic [PHY_ID_W-1:0]       rename_log_new_phy_id [0:`RENAME_WIDTH-1];
  logic [PHY_ID_W-1:0]       rename_log_old_phy_id [0:`RENAME_WIDTH-1];
  logic [`RENAME_WIDTH-1:0]  rename_log_valid;
  logic                      log_rename_ready;
  logic [`COMMIT_WIDTH-1:0]  commit_log_pop_valid;
  logic                      commit_log_flush;
  logic [PHY_ID_W-1:0]       commit_rat_release_phy_id [0:`COMMIT_WIDTH-1];
  logic [`COMMIT_WIDTH-1:0]  commit_rat_release_phy_id_valid;
  logic                      commit_rat_release_map;
  logic [PHY_ID_W-1:0]       commit_rat_commit_phy_id [0:`COMMIT_WIDTH-1];
  logic [`COMMIT_WIDTH-1:0]  commit_rat_commit_phy_id_valid;
  logic                      commit_rat_commit_map;
  logic [PHY_ID_W-1:0]       commit_rat_restore_new_phy_id;
  logic [PHY_ID_W-1:0]       commit_rat_restore_old_phy_id;
  logic                      commit_rat_restore_map;
  logic                      log_flush_done;
  logic                      log_error;

  modport master (
    input  rename_log_new_phy_id, rename_log_old_phy_id, rename_log_valid,
    input  commit_log_pop_valid, commit_log_flush,
    output log_rename_ready,
    output commit_rat_release_phy_id, commit_rat_release_phy_id_valid, commit_rat_release_map,
    output commit_rat_commit_phy_id, commit_rat_commit_phy_id_valid, commit_rat_commit_map,
    output commit_rat_restore_new_phy_id, commit_rat_restore_old_phy_id, commit_rat_restore_map,
    output log_flush_done, log_error
  );

  modport slave (
    output rename_log_new_phy_id, rename_log_old_phy_id, rename_log_valid,
    output commit_log_pop_valid, commit_log_flush,
    input  log_rename_ready,
    input  commit_rat_release_phy_id, commit_rat_release_phy_id_valid, commit_rat_release_map,
    input  commit_rat_commit_phy_id, commit_rat_commit_phy_id_valid, commit_rat_commit_map,
    input  commit_rat_restore_new_phy_id, commit_rat_restore_old_phy_id, commit_rat_restore_map,
    input  log_flush_done, log_error
  );
endinterface

// File: rtl/rat_rename_log.sv
// rat_rename_log: rename-order log of (new, old) physical ID pairs.
// Pushes at rename, retires oldest entries toward the RAT (release old /
// commit new IDs), and on flush walks uncommitted entries youngest-first
// driving one restore per cycle, then pulses log_flush_done.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - rat_rename_log_if.master (push, pop/flush, RAT outputs)
// Optional: define RAT_LOG_CHECK_EN to enable the sticky log_error checker;
// otherwise log_error is tied low.
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef PHY_REG_ID_WIDTH
`define PHY_REG_ID_WIDTH 7
`endif

module rat_rename_log #(
  parameter int LOG_DEPTH = 32,
  parameter int PHY_ID_W  = `PHY_REG_ID_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  rat_rename_log_if.master bus
);
  localparam int RW    = `RENAME_WIDTH;
  localparam int CW    = `COMMIT_WIDTH;
  localparam int IDX_W = $clog2(LOG_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(LOG_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]     count, free_slots, pop_cnt, push_cnt;
  logic [CW-1:0]        pop_eff;
  logic                 ready, push_en, restore_map, flush_done;
  logic [IDX_W-1:0]     walk_idx;
  logic [PHY_ID_W-1:0]  new_mem [LOG_DEPTH];
  logic [PHY_ID_W-1:0]  old_mem [LOG_DEPTH];

  assign count      = tail_q - head_q;
  assign free_slots = DEPTH_P - count;
  // Depends only on registered state so rename never sees a comb path.
  assign ready      = (state_q == S_IDLE) && (free_slots >= PTR_W'(RW));
  assign push_en    = ready && !bus.commit_log_flush;
  assign walk_idx   = IDX_W'(tail_q - 1'b1);

  // Pop qualification: IDLE only, lanes beyond the current count ignored.
  always_comb begin
    pop_eff = '0;
    pop_cnt = '0;
    for (int unsigned i = 0; i < CW; i++) begin
      if ((state_q == S_IDLE) && bus.commit_log_pop_valid[i] && (PTR_W'(i) < count)) begin
        pop_eff[i] = 1'b1;
        pop_cnt    = pop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    push_cnt = '0;
    for (int unsigned i = 0; i < RW; i++) begin
      if (bus.rename_log_valid[i]) push_cnt = push_cnt + 1'b1;
    end
  end

  // Retire lanes read entries head+i combinationally.
  always_comb begin
    logic [IDX_W-1:0] rd_idx;
    for (int unsigned i = 0; i < CW; i++) begin
      rd_idx = IDX_W'(head_q + PTR_W'(i));
      bus.commit_rat_release_phy_id[i] = pop_eff[i] ? old_mem[rd_idx] : '0;
      bus.commit_rat_commit_phy_id[i]  = pop_eff[i] ? new_mem[rd_idx] : '0;
    end
  end

  assign bus.commit_rat_release_phy_id_valid = pop_eff;
  assign bus.commit_rat_commit_phy_id_valid  = pop_eff;
  assign bus.commit_rat_release_map          = |pop_eff;
  assign bus.commit_rat_commit_map           = |pop_eff;
  assign bus.log_rename_ready                = ready;

  // Next-state / pointer logic.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q + pop_cnt;
    tail_d      = push_en ? (tail_q + push_cnt) : tail_q;
    restore_map = 1'b0;
    flush_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Pops in the flush cycle retire first; only the remainder is walked.
        if (bus.commit_log_flush) begin
          state_d = (tail_q == head_d) ? S_DONE : S_WALK;
        end
      end
      S_WALK: begin
        restore_map = 1'b1;
        tail_d      = tail_q - 1'b1;
        if (count <= PTR_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        flush_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Entry storage needs no reset: every read is qualified by pointer state.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int unsigned i = 0; i < RW; i++) begin
        if (bus.rename_log_valid[i]) begin
          new_mem[IDX_W'(tail_q + PTR_W'(i))] <= bus.rename_log_new_phy_id[i];
          old_mem[IDX_W'(tail_q + PTR_W'(i))] <= bus.rename_log_old_phy_id[i];
        end
      end
    end
  end

  assign bus.commit_rat_restore_map        = restore_map;
  assign bus.commit_rat_restore_new_phy_id = restore_map ? new_mem[walk_idx] : '0;
  assign bus.commit_rat_restore_old_phy_id = restore_map ? old_mem[walk_idx] : '0;
  assign bus.log_flush_done                = flush_done;

`ifdef RAT_LOG_CHECK_EN
  logic err_q, err_set;

  always_comb begin
    err_set = 1'b0;
    if ((|bus.rename_log_valid) && !ready) err_set = 1'b1;
    // A valid mask is a prefix from lane 0 iff v & (v+1) == 0.
    if ((bus.rename_log_valid & (bus.rename_log_valid + 1'b1)) != '0) err_set = 1'b1;
    if ((bus.commit_log_pop_valid & (bus.commit_log_pop_valid + 1'b1)) != '0) err_set = 1'b1;
    if ((|bus.commit_log_pop_valid) && (state_q != S_IDLE)) err_set = 1'b1;
    for (int unsigned i = 0; i < CW; i++) begin
      if (bus.commit_log_pop_valid[i] && (PTR_W'(i) >= count)) err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign bus.log_error = err_q;
`else
  assign bus.log_error = 1'b0;
`endif

endmodule

// File: tb/tb_rat_rename_log.sv
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef PHY_REG_ID_WIDTH
`define PHY_REG_ID_WIDTH 7
`endif

module tb_rat_rename_log;
  localparam int RW    = `RENAME_WIDTH;
  localparam int CW    = `COMMIT_WIDTH;
  localparam int PW    = `PHY_REG_ID_WIDTH;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic [PW-1:0] nw;
    logic [PW-1:0] od;
  } pair_t;

  logic  clk = 1'b0;
  logic  rst;
  int    total = 0;
  int    bad   = 0;

  // Reference model: queue of live entries (oldest at front) and flush phase
  // (0 = accepting, 1 = undoing youngest entries, 2 = completion pulse).
  pair_t q[$];
  int    phase = 0;
  bit    err_m = 1'b0;

  rat_rename_log_if #(.PHY_ID_W(PW)) bus ();

  rat_rename_log #(.LOG_DEPTH(DEPTH), .PHY_ID_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int nr, input int np, input bit fl);
    bus.rename_log_valid     = '0;
    bus.commit_log_pop_valid = '0;
    for (int i = 0; i < nr; i++) bus.rename_log_valid[i] = 1'b1;
    for (int i = 0; i < np; i++) bus.commit_log_pop_valid[i] = 1'b1;
    bus.commit_log_flush = fl;
  endtask

  task automatic rand_ids();
    for (int i = 0; i < RW; i++) begin
      bus.rename_log_new_phy_id[i] = PW'($urandom);
      bus.rename_log_old_phy_id[i] = PW'($urandom);
    end
  endtask

  // Check all outputs for the current cycle against the model, then clock
  // once and advance the model with the inputs that were sampled.
  task automatic do_cycle();
    int            sz, n;
    bit            rdy, fl;
    logic [CW-1:0] pv_e, pv_in;
    logic [RW-1:0] rv_in;
    logic [63:0]   rel_e, com_e, rel_o, com_o, rn_e, ro_e;
    pair_t         lanes [RW];
    #1;
    sz    = q.size();
    rdy   = (phase == 0) && (DEPTH - sz >= RW);
    pv_in = bus.commit_log_pop_valid;
    rv_in = bus.rename_log_valid;
    fl    = bus.commit_log_flush;
    for (int i = 0; i < RW; i++) lanes[i] = '{bus.rename_log_new_phy_id[i], bus.rename_log_old_phy_id[i]};
    pv_e = '0; rel_e = '0; com_e = '0; rel_o = '0; com_o = '0; n = 0;
    if (phase == 0) begin
      for (int i = 0; i < CW; i++) begin
        if (pv_in[i] && i < sz) begin
          pv_e[i] = 1'b1;
          rel_e[i*PW +: PW] = q[i].od;
          com_e[i*PW +: PW] = q[i].nw;
          n++;
        end
      end
    end
    for (int i = 0; i < CW; i++) begin
      rel_o[i*PW +: PW] = bus.commit_rat_release_phy_id[i];
      com_o[i*PW +: PW] = bus.commit_rat_commit_phy_id[i];
    end
    rn_e = '0; ro_e = '0;
    if (phase == 1) begin
      rn_e = 64'(q[$].nw);
      ro_e = 64'(q[$].od);
    end
    chk("ready",       64'(bus.log_rename_ready), 64'(rdy));
    chk("rel_valid",   64'(bus.commit_rat_release_phy_id_valid), 64'(pv_e));
    chk("com_valid",   64'(bus.commit_rat_commit_phy_id_valid), 64'(pv_e));
    chk("rel_map",     64'(bus.commit_rat_release_map), 64'(|pv_e));
    chk("com_map",     64'(bus.commit_rat_commit_map), 64'(|pv_e));
    chk("rel_ids",     rel_o, rel_e);
    chk("com_ids",     com_o, com_e);
    chk("restore_map", 64'(bus.commit_rat_restore_map), 64'(phase == 1));
    chk("restore_new", 64'(bus.commit_rat_restore_new_phy_id), rn_e);
    chk("restore_old", 64'(bus.commit_rat_restore_old_phy_id), ro_e);
    chk("flush_done",  64'(bus.log_flush_done), 64'(phase == 2));
    chk("log_error",   64'(bus.log_error), 64'(err_m));
`ifdef RAT_LOG_CHECK_EN
    if ((|rv_in) && !rdy) err_m = 1'b1;
    if ((rv_in & (rv_in + 1'b1)) != '0) err_m = 1'b1;
    if ((pv_in & (pv_in + 1'b1)) != '0) err_m = 1'b1;
    if ((|pv_in) && phase != 0) err_m = 1'b1;
    for (int i = 0; i < CW; i++) if (pv_in[i] && i >= sz) err_m = 1'b1;
`endif
    @(posedge clk);
    #1;
    case (phase)
      0: begin
        repeat (n) void'(q.pop_front());
        if (fl) phase = (q.size() > 0) ? 1 : 2;
        else if (rdy) for (int i = 0; i < RW; i++) if (rv_in[i]) q.push_back(lanes[i]);
      end
      1: begin
        void'(q.pop_back());
        if (q.size() == 0) phase = 2;
      end
      default: phase = 0;
    endcase
  endtask

  // Cycles from the flush cycle until the done pulse is observed (bounded).
  task automatic wait_done(output int c);
    bit seen;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 2 * DEPTH + 8) begin
      c++;
      drive(0, 0, 0);
      #1;
      seen = bus.log_flush_done;
      do_cycle();
    end
  endtask

  task automatic drain_to_idle();
    int guard = 0;
    while (phase != 0 && guard < 4 * DEPTH) begin
      guard++;
      drive(0, 0, 0);
      do_cycle();
    end
  endtask

  initial begin
    int c;
    rst = 1'b1;
    drive(0, 0, 0);
    for (int i = 0; i < RW; i++) begin
      bus.rename_log_new_phy_id[i] = '0;
      bus.rename_log_old_phy_id[i] = '0;
    end
    #1;
    chk("rst_ready",       64'(bus.log_rename_ready), 64'd1);
    chk("rst_rel_map",     64'(bus.commit_rat_release_map), 64'd0);
    chk("rst_restore_map", 64'(bus.commit_rat_restore_map), 64'd0);
    chk("rst_done",        64'(bus.log_flush_done), 64'd0);
    chk("rst_error",       64'(bus.log_error), 64'd0);
    chk("rst_restore_new", 64'(bus.commit_rat_restore_new_phy_id), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Push two, pop two.
    bus.rename_log_new_phy_id[0] = PW'(40); bus.rename_log_old_phy_id[0] = PW'(5);
    bus.rename_log_new_phy_id[1] = PW'(41); bus.rename_log_old_phy_id[1] = PW'(6);
    drive(2, 0, 0);
    do_cycle();
    drive(0, 2, 0);
    #1;
    chk("t1_rel0", 64'(bus.commit_rat_release_phy_id[0]), 64'd5);
    chk("t1_rel1", 64'(bus.commit_rat_release_phy_id[1]), 64'd6);
    chk("t1_com0", 64'(bus.commit_rat_commit_phy_id[0]), 64'd40);
    chk("t1_com1", 64'(bus.commit_rat_commit_phy_id[1]), 64'd41);
    do_cycle();

    // Push three, flush with no pop.
    for (int i = 0; i < 3; i++) begin
      bus.rename_log_new_phy_id[i] = PW'(10 + i);
      bus.rename_log_old_phy_id[i] = PW'(1 + i);
    end
    drive(3, 0, 0);
    do_cycle();
    drive(0, 0, 1);
    do_cycle();
    drive(0, 0, 0);
    #1;
    chk("t2_first_restore_new", 64'(bus.commit_rat_restore_new_phy_id), 64'd12);
    chk("t2_first_restore_old", 64'(bus.commit_rat_restore_old_phy_id), 64'd3);
    do_cycle();
    wait_done(c);
    chk("t2_done_latency", 64'(c + 1), 64'd4);
    drive(0, 0, 0);
    do_cycle();

    // Same entries, pop lane 0 together with flush.
    drive(3, 0, 0);
    do_cycle();
    drive(0, 1, 1);
    #1;
    chk("t3_rel0", 64'(bus.commit_rat_release_phy_id[0]), 64'd1);
    do_cycle();
    wait_done(c);
    chk("t3_done_latency", 64'(c), 64'd3);
    drive(0, 0, 0);
    do_cycle();

    // Flush on an empty log.
    drive(0, 0, 1);
    do_cycle();
    wait_done(c);
    chk("t5_done_latency", 64'(c), 64'd1);

    // Fill to full, then pop COMMIT_WIDTH.
    for (int k = 0; k < DEPTH / RW; k++) begin
      rand_ids();
      drive(RW, 0, 0);
      do_cycle();
    end
    drive(0, 0, 0);
    #1;
    chk("full_ready", 64'(bus.log_rename_ready), 64'd0);
    drive(0, CW, 0);
    do_cycle();
    drive(0, 0, 0);
    #1;
    chk("after_pop_ready", 64'(bus.log_rename_ready), 64'd1);
    do_cycle();

    // Random traffic, well beyond 3*LOG_DEPTH pushes, across flushes.
    for (int k = 0; k < 400; k++) begin
      rand_ids();
      drive(int'($urandom_range(0, RW)), int'($urandom_range(0, CW)), ($urandom_range(0, 24) == 0));
      do_cycle();
    end
    drain_to_idle();

    // Empty the log via a flush, then reset in the middle of a walk.
    drive(0, 0, 1);
    do_cycle();
    drain_to_idle();
    rand_ids();
    drive(3, 0, 0);
    do_cycle();
    drive(0, 0, 1);
    do_cycle();
    drive(0, 0, 0);
    do_cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("midwalk_restore_map", 64'(bus.commit_rat_restore_map), 64'd0);
    chk("midwalk_ready",       64'(bus.log_rename_ready), 64'd1);
    chk("midwalk_done",        64'(bus.log_flush_done), 64'd0);
    chk("midwalk_error",       64'(bus.log_error), 64'd0);
    q.delete();
    phase = 0;
    err_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 0, 0);
    do_cycle();

    // Fill, then push while full; error (if enabled) stays set until reset.
    for (int k = 0; k < DEPTH / RW + 2; k++) begin
      rand_ids();
      drive(RW, 0, 0);
      do_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0);
      do_cycle();
    end
`ifdef RAT_LOG_CHECK_EN
    chk("err_sticky", 64'(bus.log_error), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rat_rename_log.md
# rat_rename_log

Rename-order log of physical register mappings sitting between rename and commit. It is the producer side of the RAT's commit-side ports. On each rename it records the (new, old) physical ID pair for every destination-writing instruction. At retirement it drives `commit_rat_release_*` (old IDs) and `commit_rat_commit_*` (new IDs). On a pipeline flush it walks the uncommitted entries youngest-first and drives `commit_rat_restore_*` one entry per cycle until the RAT is back to architectural state.

## Interface
Parameters:
- LOG_DEPTH, 32, number of log entries; power of two, at least `RENAME_WIDTH` and at least `COMMIT_WIDTH`.
- PHY_ID_W, `PHY_REG_ID_WIDTH`, physical register ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rename_log_new_phy_id[0:`RENAME_WIDTH-1]  in  PHY_ID_W  newly allocated IDs.
- rename_log_old_phy_id[0:`RENAME_WIDTH-1]  in  PHY_ID_W  previous mapping of the same architectural register.
- rename_log_valid  in  `RENAME_WIDTH  per-lane push; contiguous from lane 0.
- log_rename_ready  out  1  push accepted this cycle.
- commit_log_pop_valid  in  `COMMIT_WIDTH  per-lane retire of the oldest entries; contiguous from lane 0.
- commit_log_flush  in  1  squash all entries not popped this cycle.
- commit_rat_release_phy_id[0:`COMMIT_WIDTH-1]  out  PHY_ID_W  old IDs of retiring entries.
- commit_rat_release_phy_id_valid  out  `COMMIT_WIDTH  per-lane release valid.
- commit_rat_release_map  out  1  any release lane valid.
- commit_rat_commit_phy_id[0:`COMMIT_WIDTH-1]  out  PHY_ID_W  new IDs of retiring entries.
- commit_rat_commit_phy_id_valid  out  `COMMIT_WIDTH  per-lane commit valid.
- commit_rat_commit_map  out  1  any commit lane valid.
- commit_rat_restore_new_phy_id  out  PHY_ID_W  new ID of the entry being undone.
- commit_rat_restore_old_phy_id  out  PHY_ID_W  old ID of the entry being undone.
- commit_rat_restore_map  out  1  restore valid.
- log_flush_done  out  1  one-cycle pulse when the walk completes.
- log_error  out  1  sticky protocol error (see Configuration).

## Operation
- Storage is a circular buffer with head and tail pointers of width log2(LOG_DEPTH)+1 (wrap bit).
  - count = tail − head, modulo 2·LOG_DEPTH.
  - full when count = LOG_DEPTH; empty when count = 0.
- State machine: IDLE, WALK, DONE.
  - IDLE → WALK on flush when the post-pop count is greater than 0.
  - IDLE → DONE on flush when the post-pop count is 0.
  - WALK → DONE when count reaches 0.
  - DONE → IDLE unconditionally.
- Push:
  - log_rename_ready = (state == IDLE) && (LOG_DEPTH − count ≥ `RENAME_WIDTH`). It is registered-state-derived, with no path from inputs.
  - Lane i is written at tail+i; tail advances by popcount(rename_log_valid).
  - Any push made while ready = 0, or in the same cycle as flush, is dropped.
- Pop, IDLE only:
  - Lane i release/commit outputs come combinationally from entry head+i, qualified by commit_log_pop_valid[i].
  - The map outputs are the OR of the lane valids. Head advances by popcount.
  - Pop lanes beyond count are ignored.
- Flush:
  - Pops in the flush cycle are honoured first.
  - In WALK, restore outputs present entry tail−1, restore_map = 1, and tail decrements each cycle.
  - Pop and push inputs are ignored in WALK and DONE. Flush outside IDLE is ignored.
- DONE asserts log_flush_done for one cycle. Head and tail are equal afterwards.

## Timing
- Reset (asynchronous, immediate, also mid-walk):
  - head = tail = 0, state = IDLE.
  - All valid and map outputs are 0, log_rename_ready = 1, log_flush_done = 0, log_error = 0.
  - ID outputs are 0.
- An entry pushed in cycle N is poppable in N+1.
- Pop outputs are combinational from pop_valid in the same cycle. The RAT samples them on the next edge.
- Flush in cycle N with k remaining entries:
  - restore_map is high in N+1 through N+k, youngest entry first.
  - log_flush_done is high in N+k+1.
  - log_rename_ready returns to 1 in N+k+2.
- k = 0: done pulse in N+1.
- Full log: ready = 0. A pop in the same cycle does not raise ready until the next cycle.

## Configuration
- `RAT_LOG_CHECK_EN` defined: log_error is set sticky on any of these:
  - push while ready = 0;
  - non-contiguous valid lanes;
  - pop lanes exceeding count;
  - pop while not IDLE.

  It is cleared only by rst.
- Not defined: log_error is tied to 0 and the checking logic is absent. Functional behaviour is identical.

## Test plan
- Reset, push lanes 0–1 (new 40/41, old 5/6), then next cycle pop lanes 0–1 → release IDs 5/6, commit IDs 40/41, both map outputs = 1.
- Push 3 entries (new 10/11/12, old 1/2/3), flush with no pop → restore pairs (12,3), (11,2), (10,1) on consecutive cycles, then a one-cycle done pulse, then ready = 1.
- Same 3 entries, pop lane 0 together with flush → lane 0 releases old ID 1; restores (12,3), (11,2) only; done 3 cycles after the flush.
- Fill to LOG_DEPTH → ready = 0. Pop `COMMIT_WIDTH` entries → ready = 1 the next cycle. Pointers wrap correctly across 3·LOG_DEPTH pushes.
- Flush on an empty log → done pulse in the next cycle, restore_map never asserted.
- Assert rst in the middle of a walk → restore_map drops immediately; after release, count = 0 and ready = 1. With `RAT_LOG_CHECK_EN`, pushing while full sets log_error = 1 and it stays set until rst.
